reset_sequencer: RTL
====================

# reset_sequencer

Reset sequencer and watchdog for the soc. It sits between the PLL-derived system clock and the soc `rst` input, and replaces free-running periodic reset with controlled reset events. It stretches reset for a fixed number of cycles after any reset event, then enforces a hold-off window before new reset requests are accepted. Requests come from the CPU (software), an external pin and a built-in watchdog; the block records which source caused the last reset and counts reset events.

## Interface
- `RST_CYCLES`, 5: cycles `cpu_rst` is held high per reset event; must be ≥1.
- `HOLDOFF`, 16: cycles after `cpu_rst` falls during which requests are ignored; must be ≥1.
- `WDT_BITS`, 13: watchdog counter width.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sw_req` in 1: software reset request, level, synchronous to `clk`.
- `ext_req` in 1: external reset request, level, asynchronous; passes through a 2-flop synchronizer.
- `wdt_en` in 1: watchdog enable, synchronous.
- `wdt_kick` in 1: watchdog restart, single-cycle or level, synchronous.
- `cpu_rst` out 1: active-high reset to the soc, registered.
- `running` out 1: high while in RUN, registered.
- `cause` out 4: one-hot-or-more cause of the last reset. Bit 0 = POR/`rst_n`, bit 1 = sw, bit 2 = ext, bit 3 = wdt.
- `reset_count` out 8: number of requested resets since `rst_n`, saturating.

## Operation
- States: ASSERT, HOLDOFF, RUN. A single down-counter `cnt` serves both ASSERT and HOLDOFF and is wide enough for max(`RST_CYCLES`, `HOLDOFF`).
- `rst_n`=0 at an edge:
  - state←ASSERT, `cnt`←`RST_CYCLES`-1.
  - `cpu_rst`←1, `running`←0, `cause`←4'b0001, `reset_count`←0.
  - Watchdog counter←0; both synchronizer flops←0.
- ASSERT: if `cnt`==0 then state←HOLDOFF, `cnt`←`HOLDOFF`-1, `cpu_rst`←0; otherwise `cnt`−1. All requests are ignored.
- HOLDOFF: if `cnt`==0 then state←RUN, `running`←1; otherwise `cnt`−1. All requests are ignored and not latched.
- RUN: `req` = `sw_req` | `ext_sync` | `wdt_to`. If `req`:
  - state←ASSERT, `cnt`←`RST_CYCLES`-1, `cpu_rst`←1, `running`←0.
  - `cause`←{`wdt_to`, `ext_sync`, `sw_req`, 0}, so all simultaneous sources are recorded.
  - `reset_count`←`reset_count`+1, saturating at 255.
- Watchdog:
  - Counter `wdt` is cleared whenever state≠RUN, `wdt_en`=0, or `wdt_kick`=1.
  - Otherwise it increments in RUN.
  - `wdt_to` = RUN & `wdt_en` & !`wdt_kick` & (`wdt`==all ones). Kick wins over timeout in the same cycle.
- Held requests: a level request still present at RUN entry triggers a new reset on the first RUN cycle, giving a repeating reset loop.
- `cause` and `reset_count` persist across requested resets; only `rst_n` clears them.

## Timing
- Reset values: `cpu_rst`=1, `running`=0, `cause`=4'b0001, `reset_count`=0.
- POR: let E0 be the first edge with `rst_n`=1. `cpu_rst` stays 1 through E0..E(`RST_CYCLES`-2) and falls at edge E(`RST_CYCLES`-1). With defaults it falls at E4.
- `running` rises `HOLDOFF` edges after `cpu_rst` falls. With defaults: E20.
- Request latency:
  - `sw_req`/watchdog high before RUN edge E: `cpu_rst`=1 and `running`=0 after E.
  - `ext_req`: add 2 cycles of synchronizer latency.
- Each requested reset holds `cpu_rst` high for exactly `RST_CYCLES` cycles, followed by `HOLDOFF` cycles before the next request is honoured.
- Timeout: with `wdt_en`=1, no kicks and RUN entered at edge R, the counter reaches all ones at R+2^`WDT_BITS`-1 and `cpu_rst` rises at the following edge.
- `rst_n` low mid-sequence overrides every state on that edge.

## Test plan
- POR: `rst_n` low for 3 cycles, then high → `cpu_rst` falls at E4, `running` rises at E20, `cause`=0001, `reset_count`=0.
- SW reset: 1-cycle `sw_req` in RUN → `cpu_rst` high for 5 cycles starting the next edge, `cause`=0010, `reset_count`=1. A second `sw_req` during HOLDOFF is ignored: `reset_count` stays 1.
- Simultaneous sources: `sw_req` and `ext_req` both pending at the same RUN edge (ext pre-synchronized) → `cause`=0110, `reset_count` increments by 1.
- Watchdog with `WDT_BITS`=4, no kick → `cpu_rst` rises at R+16 and `cause`=1000.
  - Kick on the timeout cycle → no reset.
  - `wdt_en`=0 → never resets.
- Held `ext_req`=1 for 100 cycles after RUN → repeated resets with period `RST_CYCLES`+`HOLDOFF`+1 = 22 cycles; `reset_count` increments each time and saturates at 255 with `reset_count` preloaded to 254 via extended stimulus.
- `rst_n` low during HOLDOFF with `reset_count`=3 → next edge: ASSERT, `cause`=0001, `reset_count`=0, `running`=0.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Request and status bundle between the reset sequencer and the SoC logic around it.
// The master drives reset requests and watchdog control; the slave (sequencer) reports reset status.
interface reset_sequencer_if;
    logic       sw_req;
    logic       ext_req;
    logic       wdt_en;
    logic       wdt_kick;
    logic       cpu_rst;
    logic       running;
    logic [3:0] cause;
    logic [7:0] reset_count;

    modport master (
        output sw_req, ext_req, wdt_en, wdt_kick,
        input  cpu_rst, running, cause, reset_count
    );

    modport slave (
        input  sw_req, ext_req, wdt_en, wdt_kick,
        output cpu_rst, running, cause, reset_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer with watchdog: stretches each reset event, then holds off further requests,
// and records the cause of the last reset plus a saturating count of requested resets.
module reset_sequencer #(
    parameter int RST_CYCLES = 5,
    parameter int HOLDOFF    = 16,
    parameter int WDT_BITS   = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    reset_sequencer_if.slave bus
);
    localparam int CNT_MAX = (RST_CYCLES > HOLDOFF) ? RST_CYCLES : HOLDOFF;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                running_q, running_d;
    logic [3:0]          cause_q, cause_d;
    logic [7:0]          count_q, count_d;
    logic [WDT_BITS-1:0] wdt_q, wdt_d;
    logic                ext_meta_q;
    logic                ext_sync_q;
    logic                wdt_to;
    logic                req;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= RST_LOAD;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            cause_q    <= 4'b0001;
            count_q    <= 8'd0;
            wdt_q      <= '0;
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_rst_q  <= cpu_rst_d;
            running_q  <= running_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
            wdt_q      <= wdt_d;
            ext_meta_q <= bus.ext_req;
            ext_sync_q <= ext_meta_q;
        end
    end

    // A kick in the same cycle as the terminal count suppresses the timeout.
    assign wdt_to = (state_q == ST_RUN) && bus.wdt_en && !bus.wdt_kick && (&wdt_q);
    assign req    = bus.sw_req || ext_sync_q || wdt_to;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpu_rst_d = cpu_rst_q;
        running_d = running_q;
        cause_d   = cause_q;
        count_d   = count_q;

        if ((state_q != ST_RUN) || !bus.wdt_en || bus.wdt_kick) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + 1'b1;
        end

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_HOLDOFF;
                    cnt_d     = HOLD_LOAD;
                    cpu_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d   = ST_RUN;
                    running_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (req) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = RST_LOAD;
                    cpu_rst_d = 1'b1;
                    running_d = 1'b0;
                    cause_d   = {wdt_to, ext_sync_q, bus.sw_req, 1'b0};
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_ASSERT;
                cnt_d     = RST_LOAD;
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
            end
        endcase
    end

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.running     = running_q;
    assign bus.cause       = cause_q;
    assign bus.reset_count = count_q;
endmodule
